// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, width defaults and command-type codes for the SPI master
package spi_pkg;
  localparam int CMD_W_DEF = 10;
  localparam int RD_W_DEF = 8;
  localparam logic [1:0] WR_ADDR = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] RD_ADDR = 2'b10;
  localparam logic [1:0] RD_DATA = 2'b11;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    CMD   = 3'd2,
    SHIFT = 3'd3,
    WAIT  = 3'd4,
    RECV  = 3'd5,
    GAP   = 3'd6
  } state_t;
endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: load/shift-left register exposing its top OW bits (clk, rst, load, shift, sin, d -> q)
module spi_shift_reg #(
  parameter int W = 8,
  parameter int OW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic          sin,
  input  logic [W-1:0]  d,
  output logic [OW-1:0] q
);
  logic [W-1:0] r_q;
  always_ff @(posedge clk) begin
    if (rst) r_q <= '0;
    else if (load) r_q <= d;
    else if (shift) r_q <= {r_q[W-2:0], sin};
  end
  assign q = r_q[W-1 -: OW];
endmodule

// File: rtl/spi_master_gm.sv
// spi_master_gm: SS_n-framed SPI master shifting cmd_data out on MOSI and capturing RD_W bits from MISO on read-data frames
module spi_master_gm
  import spi_pkg::*;
#(
  parameter int CMD_W = CMD_W_DEF,
  parameter int RD_W = RD_W_DEF,
  parameter int MISO_DELAY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CMD_W-1:0] cmd_data,
  output logic            SS_n,
  output logic            MOSI,
  input  logic            MISO,
  output logic            busy,
  output logic            done,
  output logic [RD_W-1:0] rd_data,
  output logic            rd_valid,
  output logic [2:0]      cs_sva
);
  localparam int CNT_W = $clog2(CMD_W + RD_W + MISO_DELAY + 1);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_is_read;
  logic w_tx_load;
  logic w_tx_shift;
  logic w_rx_shift;
  logic w_tx_msb;
  logic [RD_W-2:0] w_rx_q;
  assign w_tx_load = (r_state == IDLE) && start;
  assign w_tx_shift = (r_state == CMD) || (r_state == SHIFT);
  assign w_rx_shift = r_state == RECV;
  assign cs_sva = r_state;
  spi_shift_reg #(.W(CMD_W), .OW(1)) u_tx (
    .clk(clk), .rst(rst), .load(w_tx_load), .shift(w_tx_shift),
    .sin(1'b0), .d(cmd_data), .q(w_tx_msb)
  );
  spi_shift_reg #(.W(RD_W-1), .OW(RD_W-1)) u_rx (
    .clk(clk), .rst(rst), .load(1'b0), .shift(w_rx_shift),
    .sin(MISO), .d('0), .q(w_rx_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_is_read <= 1'b0;
      SS_n <= 1'b1;
      MOSI <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      done <= 1'b0;
      rd_valid <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= SEL;
          r_is_read <= cmd_data[CMD_W-1 -: 2] == RD_DATA;
          SS_n <= 1'b0;
          MOSI <= 1'b0;
          busy <= 1'b1;
        end
        SEL: begin
          r_state <= CMD;
          MOSI <= w_tx_msb;
        end
        CMD: begin
          r_state <= SHIFT;
          r_cnt <= '0;
          MOSI <= w_tx_msb;
        end
        SHIFT: if (r_cnt == CNT_W'(CMD_W - 1)) begin
          r_cnt <= '0;
          MOSI <= 1'b0;
          r_state <= r_is_read ? WAIT : GAP;
          SS_n <= !r_is_read;
          done <= !r_is_read;
          busy <= r_is_read;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          MOSI <= w_tx_msb;
        end
        WAIT: begin
          r_cnt <= (r_cnt == CNT_W'(MISO_DELAY - 1)) ? '0 : r_cnt + 1'b1;
          r_state <= (r_cnt == CNT_W'(MISO_DELAY - 1)) ? RECV : WAIT;
        end
        RECV: if (r_cnt == CNT_W'(RD_W - 1)) begin
          r_cnt <= '0;
          rd_data <= {w_rx_q, MISO};
          r_state <= GAP;
          SS_n <= 1'b1;
          done <= 1'b1;
          rd_valid <= 1'b1;
          busy <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        GAP: r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_gm.sv
// tb_spi_master_gm: directed table-driven bench for spi_master_gm with a cycle-indexed MISO slave model
module tb_spi_master_gm;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [9:0] cmd_data;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic busy;
  logic done;
  logic [7:0] rd_data;
  logic rd_valid;
  logic [2:0] cs_sva;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [9:0] cmd;
    logic [7:0] miso;
    bit pulse;
    int exp_ss;
    int exp_rv;
    logic [7:0] exp_rd;
  } vec_t;
  vec_t vecs[6];
  spi_master_gm dut (
    .clk(clk), .rst(rst), .start(start), .cmd_data(cmd_data),
    .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .cs_sva(cs_sva)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run_frame(input vec_t v, input int idx);
    logic [9:0] sh = '0;
    logic mosi_sel = 1'b1;
    logic mosi_cmd = 1'b0;
    int ss_low = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int rv_cnt = 0;
    int rv_with_done = 0;
    @(negedge clk);
    start = 1'b1;
    cmd_data = v.cmd;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0;
        cmd_data = ~v.cmd;
      end
      if (v.pulse && c == 5) begin
        start = 1'b1;
        cmd_data = 10'h3FF;
      end
      if (v.pulse && c == 6) start = 1'b0;
      MISO = (c >= 15 && c < 23) ? v.miso[22 - c] : 1'b0;
      if (c == 0) mosi_sel = MOSI;
      if (c == 1) mosi_cmd = MOSI;
      if (c >= 2 && c <= 11) sh[11 - c] = MOSI;
      if (SS_n == 1'b0) ss_low++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (rd_valid) rv_cnt++;
      if (rd_valid && done) rv_with_done++;
    end
    MISO = 1'b0;
    check($sformatf("v%0d mosi_sel", idx), 32'(mosi_sel), 32'd0);
    check($sformatf("v%0d mosi_cmd", idx), 32'(mosi_cmd), 32'(v.cmd[9]));
    check($sformatf("v%0d mosi_shift", idx), 32'(sh), 32'(v.cmd));
    check($sformatf("v%0d ss_low", idx), 32'(ss_low), 32'(v.exp_ss));
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt), 32'(v.exp_ss));
    check($sformatf("v%0d done_count", idx), 32'(done_cnt), 32'd1);
    check($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(v.exp_ss));
    check($sformatf("v%0d rd_valid_count", idx), 32'(rv_cnt), 32'(v.exp_rv));
    check($sformatf("v%0d rd_valid_with_done", idx), 32'(rv_with_done), 32'(v.exp_rv));
    check($sformatf("v%0d rd_data", idx), 32'(rd_data), 32'(v.exp_rd));
  endtask
  initial begin
    vecs[0] = '{10'b00_1010_1010, 8'h00, 1'b0, 12, 0, 8'h00};
    vecs[1] = '{10'b11_0000_0000, 8'hA5, 1'b0, 23, 1, 8'hA5};
    vecs[2] = '{10'b01_0101_0101, 8'hFF, 1'b1, 12, 0, 8'hA5};
    vecs[3] = '{10'b10_1100_0011, 8'h00, 1'b0, 12, 0, 8'hA5};
    vecs[4] = '{10'b11_1111_1111, 8'h3C, 1'b1, 23, 1, 8'h3C};
    vecs[5] = '{10'b00_1111_1111, 8'hC3, 1'b0, 12, 0, 8'h3C};
    rst = 1'b1;
    start = 1'b0;
    cmd_data = '0;
    MISO = 1'b0;
    repeat (3) @(negedge clk);
    check("reset SS_n", 32'(SS_n), 32'd1);
    check("reset MOSI", 32'(MOSI), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    check("reset state", 32'(cs_sva), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    begin
      int extra = 0;
      start = 1'b1;
      cmd_data = 10'b11_0000_0000;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c == 0) start = 1'b0;
        MISO = (c >= 15) ? 1'b1 : 1'b0;
        if (done || rd_valid) extra++;
      end
      rst = 1'b1;
      @(negedge clk);
      check("midrst SS_n", 32'(SS_n), 32'd1);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst done", 32'(done), 32'd0);
      check("midrst rd_valid", 32'(rd_valid), 32'd0);
      check("midrst state", 32'(cs_sva), 32'd0);
      rst = 1'b0;
      MISO = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (done || rd_valid || !SS_n) extra++;
      end
      check("midrst no activity", 32'(extra), 32'd0);
      check("midrst rd_data", 32'(rd_data), 32'd0);
    end
    foreach (vecs[i]) run_frame(vecs[i], i);
    begin
      int d1 = -1;
      int d2 = -1;
      int ndone = 0;
      int ss_high = 0;
      logic [9:0] sh2 = '0;
      @(negedge clk);
      start = 1'b1;
      cmd_data = 10'h055;
      for (int c = 0; c < 36; c++) begin
        @(negedge clk);
        if (c == 0) cmd_data = 10'h2AA;
        if (c == 14) start = 1'b0;
        if (done) begin
          ndone++;
          if (d1 < 0) d1 = c;
          else d2 = c;
        end
        if (c >= 1 && c <= 20 && SS_n) ss_high++;
        if (c >= 16 && c <= 25) sh2[25 - c] = MOSI;
      end
      check("b2b done count", 32'(ndone), 32'd2);
      check("b2b first done", 32'(d1), 32'd12);
      check("b2b done spacing", 32'(d2 - d1), 32'd14);
      check("b2b ss_high gap", 32'(ss_high), 32'd2);
      check("b2b frame2 mosi", 32'(sh2), 32'h2AA);
      check("b2b rd_data kept", 32'(rd_data), 32'h3C);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
